// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: state encoding,
// address/FIFO sizing and the destination one-hot decode.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_FIFOS = 3;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    // Binary-encoded controller states; values are kept stable for legacy tools.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

    // Destination address to one-hot FIFO select; the invalid address maps to none.
    function automatic logic [NUM_FIFOS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_FIFOS-1:0] sel;
        sel = '0;
        case (addr)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router. Decodes and latches the destination
// from the header byte, sequences header/payload/parity loading, stalls on a
// full or busy destination and aborts on a soft reset of the selected FIFO.
module router_fsm
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic                 fifo_full,
    input  logic                 fifo_empty_0,
    input  logic                 fifo_empty_1,
    input  logic                 fifo_empty_2,
    input  logic                 soft_reset_0,
    input  logic                 soft_reset_1,
    input  logic                 soft_reset_2,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic [NUM_FIFOS-1:0] fifo_sel
);

    router_state_t        state;
    router_state_t        state_next;
    logic [NUM_FIFOS-1:0] sel_next;
    logic [NUM_FIFOS-1:0] fifo_empty;
    logic [NUM_FIFOS-1:0] soft_reset;
    logic [NUM_FIFOS-1:0] addr_sel;
    logic                 soft_hit;

    assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign addr_sel   = addr_onehot(data_in);

    // Only a soft reset aimed at the FIFO this packet is going to aborts it.
    assign soft_hit = |(soft_reset & fifo_sel);

    // Next-state and destination-latch logic; soft reset overrides everything.
    always_comb begin
        state_next = state;
        sel_next   = fifo_sel;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && (data_in != ADDR_INVALID)) begin
                    sel_next = addr_sel;
                    if (|(fifo_empty & addr_sel))
                        state_next = LOAD_FIRST_DATA;
                    else
                        state_next = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (|(fifo_empty & fifo_sel))
                    state_next = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                // A full FIFO must be handled before the parity byte is accepted.
                if (fifo_full)
                    state_next = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_next = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_next = LOAD_PARITY;
                else
                    state_next = LOAD_DATA;
            end
            LOAD_PARITY: begin
                state_next = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                if (fifo_full)
                    state_next = FIFO_FULL_STATE;
                else
                    state_next = DECODE_ADDRESS;
            end
            default: begin
                state_next = DECODE_ADDRESS;
            end
        endcase

        if (soft_hit) begin
            state_next = DECODE_ADDRESS;
            sel_next   = '0;
        end
    end

    // State and destination registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            fifo_sel <= '0;
        end else begin
            state    <= state_next;
            fifo_sel <= sel_next;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        laf_state     = (state == LOAD_AFTER_FULL);
        full_state    = (state == FIFO_FULL_STATE);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                        (state == LOAD_PARITY);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

endmodule
